msrv32_regfile_sb: RTL and testbench
====================================

// Module: msrv32_regfile_sb
// PURPOSE
//  Parametrised integer register file with N combinational read ports, one write-back port
//  and a per-register scoreboard of pending writes. Sits between decode (issue/read) and
//  write-back of the msrv32 pipeline; raises stall_out when a read operand awaits a write.
//  x0 reads zero, is never written and is never busy.
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of 2, >=2)
//  NUM_RD   2  number of read ports (1..4)
//  ADDR_W  $clog2(NREGS)  register address width (derived, do not override)
// PORTS
//  clk_in        in   1              clock, all state updates on rising edge
//  reset_in      in   1              asynchronous, active-low reset
//  rs_addr_in    in   NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rs_valid_in   in   NUM_RD         port p operand is actually used this cycle
//  rs_data_out   out  NUM_RD*XLEN    read data, port p at [p*XLEN +: XLEN]
//  rs_busy_out   out  NUM_RD         port p register has a pending (unretired) write
//  stall_out     out  1              OR over p of (rs_valid_in[p] & rs_busy_out[p])
//  issue_en_in   in   1              instruction issuing that will write issue_rd_in
//  issue_rd_in   in   ADDR_W         destination of issuing instruction
//  wb_en_in      in   1              write-back strobe
//  wb_addr_in    in   ADDR_W         write-back destination
//  wb_data_in    in   XLEN           write-back data
//  flush_in      in   1              pipeline flush: clear all busy bits
//  pending_out   out  ADDR_W+1       number of registers currently busy
// BEHAVIOUR
//  - Reset (reset_in=0, async): all registers 0, all busy bits 0; outputs: rs_data_out 0,
//    rs_busy_out 0, stall_out 0, pending_out 0. Release is synchronous to next clk_in edge.
//  - Write: on posedge, if wb_en_in & wb_addr_in!=0: reg[wb_addr_in] <= wb_data_in.
//    wb to addr 0 ignored entirely (data and busy).
//  - Read: combinational, zero latency. Address 0 -> data 0, busy 0 on every port.
//  - Scoreboard, per register r!=0, evaluated at posedge in priority order:
//    1 flush_in -> busy[r]<=0 for all r (issue_en_in same cycle is dropped);
//    2 issue_en_in & issue_rd_in==r -> busy[r]<=1 (issue wins over same-cycle wb to r);
//    3 wb_en_in & wb_addr_in==r -> busy[r]<=0; else hold.
//  - Issue to an already-busy register: bit stays 1 (single-bit, no WAW counting);
//    the first write-back clears it. Decode must not issue a WAW on a busy rd.
//  - pending_out = popcount(busy), registered view (reflects state after last edge).
//  - stall_out is combinational from rs_valid_in and rs_busy_out; rs_valid_in=0 masks port.
//  - Identical addresses on several read ports return identical data/busy.
// CONFIGURATION
//  MSRV32_RF_BYPASS_EN defined: when wb_en_in & wb_addr_in==rs_addr[p] & rs_addr[p]!=0,
//    rs_data_out[p]=wb_data_in and rs_busy_out[p]=0 in the same cycle (write-to-read bypass);
//    bypass also applies when issue same cycle targets that register.
//  Not defined: reads return stored value only; busy clears one cycle after write-back, so a
//    dependent read stalls exactly one extra cycle.
// STRUCTURE
//  Package msrv32_rf_pkg: XLEN default, reg_addr_t, X0 constant, popcount function.
//  Sub-module msrv32_rf_scoreboard: busy vector, flush/issue/wb priority, pending_out count.
//  Top holds storage array, read muxes, bypass logic and stall reduction.
// TESTING
//  1 reset_in=0 mid-run with regs written -> all rs_data_out 0, pending_out 0 immediately.
//  2 wb x2<=32'h12345678, next cycle rs_addr p0=2,p1=3 -> p0=32'h12345678, p1=0, busy 0,0.
//  3 wb x0<=32'hDEADBEEF, read x0 -> 0; issue rd=0 -> pending_out stays 0.
//  4 issue rd=5, read x5 valid -> busy=1, stall_out=1, pending_out=1; wb x5<=32'hA5A5A5A5
//    -> with BYPASS_EN same cycle data A5A5A5A5, stall 0; without, stall drops next cycle.
//  5 same-cycle issue rd=7 and wb x7<=1 -> reg x7=1, busy[7]=1, pending_out=1.
//  6 issue rd=3,4,6 then flush_in with issue rd=9 -> pending_out 0, x9 not busy.

Source files
------------

// File: rtl/msrv32_rf_pkg.sv
// Shared types and helpers for the msrv32 register file and its write-back scoreboard.
// Optional write-to-read bypass in the top is enabled by defining MSRV32_RF_BYPASS_EN.
package msrv32_rf_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  // Widest busy vector popcount() accepts; callers zero-extend narrower vectors.
  localparam int MAX_REGS      = 256;

  typedef logic [$clog2(DEFAULT_NREGS)-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REGS; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/msrv32_rf_scoreboard.sv
// Per-register pending-write scoreboard: flush > issue > write-back priority, x0 never busy,
// plus a count of currently busy registers.
module msrv32_rf_scoreboard
  import msrv32_rf_pkg::*;
#(
  parameter  int NREGS  = DEFAULT_NREGS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   pending
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(X0);

  logic [NREGS-1:0]    busy_nxt;
  logic [MAX_REGS-1:0] busy_ext;

  // Issue is applied after write-back so a same-cycle issue to the same register wins.
  // NOTE: every always_comb variable gets a full default first so no path can infer a latch.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_en && wb_addr != ZERO_ADDR) busy_nxt[wb_addr] = 1'b0;
      if (issue_en && issue_rd != ZERO_ADDR) busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    busy_ext              = '0;
    busy_ext[NREGS-1:0]   = busy;
  end

  assign pending = (ADDR_W + 1)'(popcount(busy_ext));

endmodule

// File: rtl/msrv32_regfile_sb.sv
// msrv32 integer register file: NUM_RD combinational read ports, one write-back port and a
// pending-write scoreboard driving stall_out. Define MSRV32_RF_BYPASS_EN for write-to-read bypass.
module msrv32_regfile_sb
  import msrv32_rf_pkg::*;
#(
  parameter  int XLEN   = DEFAULT_XLEN,
  parameter  int NREGS  = DEFAULT_NREGS,
  parameter  int NUM_RD = 2,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr_in,
  input  logic [NUM_RD-1:0]        rs_valid_in,
  output logic [NUM_RD*XLEN-1:0]   rs_data_out,
  output logic [NUM_RD-1:0]        rs_busy_out,
  output logic                     stall_out,
  input  logic                     issue_en_in,
  input  logic [ADDR_W-1:0]        issue_rd_in,
  input  logic                     wb_en_in,
  input  logic [ADDR_W-1:0]        wb_addr_in,
  input  logic [XLEN-1:0]          wb_data_in,
  input  logic                     flush_in,
  output logic [ADDR_W:0]          pending_out
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(X0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // NOTE: the array is reset because zeroed registers must be visible on the read ports
  // immediately after reset; it is therefore built from flops, not an inferred RAM.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_en_in && wb_addr_in != ZERO_ADDR) begin
      regs[wb_addr_in] <= wb_data_in;
    end
  end

  msrv32_rf_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk      (clk_in),
    .rst_n    (reset_in),
    .issue_en (issue_en_in),
    .issue_rd (issue_rd_in),
    .wb_en    (wb_en_in),
    .wb_addr  (wb_addr_in),
    .flush    (flush_in),
    .busy     (busy),
    .pending  (pending_out)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    logic              port_busy;

    assign addr = rs_addr_in[p*ADDR_W +: ADDR_W];

    always_comb begin
      data      = '0;
      port_busy = 1'b0;
      if (addr != ZERO_ADDR) begin
        data      = regs[addr];
        port_busy = busy[addr];
`ifdef MSRV32_RF_BYPASS_EN
        // Same-cycle write-back satisfies the read, even if a new issue re-marks the register.
        if (wb_en_in && wb_addr_in == addr) begin
          data      = wb_data_in;
          port_busy = 1'b0;
        end
`endif
      end
    end

    assign rs_data_out[p*XLEN +: XLEN] = data;
    assign rs_busy_out[p]              = port_busy;
  end

  assign stall_out = |(rs_valid_in & rs_busy_out);

endmodule

// File: tb/tb_msrv32_regfile_sb.sv
// Directed, table-driven bench for msrv32_regfile_sb (default parameters, 2 read ports).
// Expectations follow MSRV32_RF_BYPASS_EN when the bench is built with it defined.
module tb_msrv32_regfile_sb;

`ifdef MSRV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [9:0]  rs_addr_in;
  logic [1:0]  rs_valid_in;
  logic [63:0] rs_data_out;
  logic [1:0]  rs_busy_out;
  logic        stall_out;
  logic        issue_en_in;
  logic [4:0]  issue_rd_in;
  logic        wb_en_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic        flush_in;
  logic [5:0]  pending_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  msrv32_regfile_sb dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .rs_addr_in  (rs_addr_in),
    .rs_valid_in (rs_valid_in),
    .rs_data_out (rs_data_out),
    .rs_busy_out (rs_busy_out),
    .stall_out   (stall_out),
    .issue_en_in (issue_en_in),
    .issue_rd_in (issue_rd_in),
    .wb_en_in    (wb_en_in),
    .wb_addr_in  (wb_addr_in),
    .wb_data_in  (wb_data_in),
    .flush_in    (flush_in),
    .pending_out (pending_out)
  );

  typedef struct {
    logic [4:0]  a0, a1;
    logic [1:0]  valid;
    logic        ie;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic [31:0] e_d0, e_d1;
    logic [1:0]  e_busy;
    logic        e_stall;
    logic [5:0]  e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [4:0] a0, a1, input logic [1:0] valid,
    input logic ie, input logic [4:0] ird,
    input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic fl,
    input logic [31:0] e_d0, e_d1, input logic [1:0] e_busy, input logic e_stall,
    input logic [5:0] e_pend);
    vec_t v;
    v.a0 = a0; v.a1 = a1; v.valid = valid; v.ie = ie; v.ird = ird;
    v.we = we; v.wa = wa; v.wd = wd; v.fl = fl;
    v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_busy = e_busy; v.e_stall = e_stall; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_en_in = 1'b0; issue_rd_in = '0;
    wb_en_in    = 1'b0; wb_addr_in  = '0; wb_data_in = '0;
    flush_in    = 1'b0; rs_valid_in = '0; rs_addr_in = '0;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] d0, d1,
                               input logic [1:0] busy, input logic stall, input logic [5:0] pend);
    check({tag, " d0"},    64'(rs_data_out[31:0]),  64'(d0));
    check({tag, " d1"},    64'(rs_data_out[63:32]), 64'(d1));
    check({tag, " busy"},  64'(rs_busy_out),        64'(busy));
    check({tag, " stall"}, 64'(stall_out),          64'(stall));
    check({tag, " pend"},  64'(pending_out),        64'(pend));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //   a0  a1  vld  ie ird  we wa  wd            fl  e_d0          e_d1          bsy   st  pend
    vecs.push_back(mk(0,  0,  2'b11, 0, 0,  0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(1,  1,  2'b00, 0, 0,  1, 2,  32'h12345678, 0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(2,  3,  2'b11, 0, 0,  0, 0,  32'h0,        0, 32'h12345678, 32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(0,  0,  2'b11, 0, 0,  1, 0,  32'hDEADBEEF, 0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(0,  2,  2'b11, 1, 0,  0, 0,  32'h0,        0, 32'h0,        32'h12345678, 2'b00, 0, 0));
    vecs.push_back(mk(0,  0,  2'b11, 0, 0,  0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(1,  1,  2'b00, 1, 5,  0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(5,  5,  2'b01, 0, 0,  1, 5,  32'hA5A5A5A5, 0,
                      BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0,
                      BYP ? 2'b00 : 2'b11, !BYP, 1));
    vecs.push_back(mk(5,  5,  2'b01, 0, 0,  0, 0,  32'h0,        0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 0, 0));
    vecs.push_back(mk(1,  1,  2'b00, 1, 7,  1, 7,  32'h1,        0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(7,  7,  2'b11, 0, 0,  0, 0,  32'h0,        0, 32'h1,        32'h1,        2'b11, 1, 1));
    vecs.push_back(mk(7,  7,  2'b00, 0, 0,  1, 7,  32'h2,        0,
                      BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, BYP ? 2'b00 : 2'b11, 0, 1));
    vecs.push_back(mk(7,  0,  2'b00, 1, 3,  0, 0,  32'h0,        0, 32'h2,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(3,  0,  2'b01, 1, 4,  0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b01, 1, 1));
    vecs.push_back(mk(3,  4,  2'b10, 1, 6,  0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b11, 1, 2));
    vecs.push_back(mk(6,  9,  2'b11, 1, 9,  0, 0,  32'h0,        1, 32'h0,        32'h0,        2'b01, 1, 3));
    vecs.push_back(mk(3,  9,  2'b11, 0, 0,  0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(0,  0,  2'b11, 1, 31, 0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b00, 0, 0));
    vecs.push_back(mk(31, 31, 2'b11, 1, 31, 0, 0,  32'h0,        0, 32'h0,        32'h0,        2'b11, 1, 1));
    vecs.push_back(mk(31, 0,  2'b01, 0, 0,  1, 31, 32'hFFFFFFFF, 0,
                      BYP ? 32'hFFFFFFFF : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, !BYP, 1));
    vecs.push_back(mk(31, 31, 2'b11, 0, 0,  0, 0,  32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 0, 0));

    // Power-on reset, checked while asserted.
    reset_in = 1'b0;
    idle_inputs();
    rs_valid_in = 2'b11;
    #2;
    check_outputs("por", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_in);
      rs_addr_in  = {vecs[i].a1, vecs[i].a0};
      rs_valid_in = vecs[i].valid;
      issue_en_in = vecs[i].ie;   issue_rd_in = vecs[i].ird;
      wb_en_in    = vecs[i].we;   wb_addr_in  = vecs[i].wa;  wb_data_in = vecs[i].wd;
      flush_in    = vecs[i].fl;
      #2;
      check_outputs($sformatf("v%0d", i), vecs[i].e_d0, vecs[i].e_d1,
                    vecs[i].e_busy, vecs[i].e_stall, vecs[i].e_pend);
    end

    // Mid-run reset with registers written and one write pending.
    @(negedge clk_in);
    idle_inputs();
    issue_en_in = 1'b1; issue_rd_in = 5'd10;
    @(negedge clk_in);
    idle_inputs();
    rs_addr_in = {5'd31, 5'd2}; rs_valid_in = 2'b11;
    #2;
    check("pre-reset pend", 64'(pending_out), 64'd1);
    check("pre-reset x2", 64'(rs_data_out[31:0]), 64'h12345678);
    reset_in = 1'b0;
    #1;
    check_outputs("mid-reset", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
    wb_en_in = 1'b1; wb_addr_in = 5'd2; wb_data_in = 32'h55;
    @(negedge clk_in);
    check("in-reset wb x2", 64'(rs_data_out[31:0]), 64'h0);
    reset_in = 1'b1;
    #2;
    check("post-reset x2", 64'(rs_data_out[31:0]), 64'h0);
    @(negedge clk_in);
    idle_inputs();
    rs_addr_in = {5'd31, 5'd2}; rs_valid_in = 2'b11;
    #2;
    check_outputs("post-reset wb", 32'h55, 32'h0, 2'b00, 1'b0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
